// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers:
//   - pipe_state_e : occupancy state of a skid stage (encoding equals entry count)
//   - per-stage control/payload widths
//   - ID/EX control field bit offsets and the NOP (bubble) control value
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // Per-stage bundle widths
  localparam int unsigned IFID_CTRL_W  = 8;
  localparam int unsigned IFID_DATA_W  = 64;
  localparam int unsigned IDEX_CTRL_W  = 8;
  localparam int unsigned IDEX_DATA_W  = 128;
  localparam int unsigned EXMEM_CTRL_W = 8;
  localparam int unsigned EXMEM_DATA_W = 96;
  localparam int unsigned MEMWB_CTRL_W = 8;
  localparam int unsigned MEMWB_DATA_W = 72;

  // ID/EX control field bit offsets
  localparam int unsigned CTRL_REGWRITE_BIT = 0;
  localparam int unsigned CTRL_MEMTOREG_BIT = 1;
  localparam int unsigned CTRL_ALUOP_LSB    = 2;
  localparam int unsigned CTRL_ALUOP_W      = 2;
  localparam int unsigned CTRL_MEMREAD_BIT  = 4;
  localparam int unsigned CTRL_MEMWRITE_BIT = 5;
  localparam int unsigned CTRL_ALUSRC_BIT   = 6;

  // NOP control: all enables low, ALUOp = 2'b11 (bubble opcode)
  localparam logic [IDEX_CTRL_W-1:0] IDEX_CTRL_NOP = 8'h0C;

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer (head + skid).
// Valid/ready on both sides, registered in_ready_o, synchronous flush,
// and a forced bubble control value whenever no entry is presented.
// Ports:
//   clk_i, rst_i (async active-low), flush_i
//   in_valid_i / in_ready_o / in_ctrl_i / in_data_i   : upstream side
//   out_valid_o / out_ready_i / out_ctrl_o / out_data_o : downstream side
//   occupancy_o : number of held entries (0..2)
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W      = 8,
  parameter int unsigned       DATA_W      = 128,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  pipe_state_e       state_q, state_d;

  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q,  in_ready_d;
  logic [1:0]        occ_q,       occ_d;

  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (in_fire) state_d = BUSY;
      BUSY: begin
        if (in_fire && !out_fire)      state_d = FULL;
        else if (!in_fire && out_fire) state_d = EMPTY;
      end
      FULL:    if (out_fire) state_d = BUSY;
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end

  // Output / datapath next values
  always_comb begin
    head_ctrl_d = head_ctrl_q;
    head_data_d = head_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      // Payload is left as is; only the control is forced to the bubble
      head_ctrl_d = CTRL_BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            head_ctrl_d = in_ctrl_i;
            head_data_d = in_data_i;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            head_ctrl_d = in_ctrl_i;
            head_data_d = in_data_i;
          end else if (in_fire) begin
            skid_ctrl_d = in_ctrl_i;
            skid_data_d = in_data_i;
          end else if (out_fire) begin
            head_ctrl_d = CTRL_BUBBLE;
          end
        end
        FULL: begin
          if (out_fire) begin
            head_ctrl_d = skid_ctrl_q;
            head_data_d = skid_data_q;
          end
        end
        default: head_ctrl_d = CTRL_BUBBLE;
      endcase
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
    // State encoding equals the entry count
    occ_d       = 2'(state_d);
  end

  // Output and buffer registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_ctrl_q <= CTRL_BUBBLE;
      head_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      head_ctrl_q <= head_ctrl_d;
      head_data_q <= head_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      occ_q       <= occ_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_ctrl_o  = head_ctrl_q;
  assign out_data_o  = head_data_q;
  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue-based reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_pipe_stage_skid;

  localparam int unsigned       CTRL_W = 8;
  localparam int unsigned       DATA_W = 128;
  localparam logic [CTRL_W-1:0] BUB    = 8'h0C;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i     = 1'b0;
  logic              in_valid_i  = 1'b0;
  logic              in_ready_o;
  logic [CTRL_W-1:0] in_ctrl_i   = '0;
  logic [DATA_W-1:0] in_data_i   = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [DATA_W-1:0] out_data_o;
  logic [1:0]        occupancy_o;

  pipe_stage_skid #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .CTRL_BUBBLE(BUB)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_ctrl_i  (in_ctrl_i),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_ctrl_o (out_ctrl_o),
    .out_data_o (out_data_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of held entries, at most two deep
  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              mq[$];
  logic              m_ready     = 1'b1;
  logic [DATA_W-1:0] m_last      = '0;
  logic              m_full_hold = 1'b0;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mq.delete();
      m_ready     = 1'b1;
      m_last      = '0;
      m_full_hold = 1'b0;
    end else begin
      logic ifire, ofire;
      ent_t e;
      ifire = in_valid_i && m_ready;
      ofire = (mq.size() > 0) && out_ready_i;
      m_full_hold = (mq.size() == 2) && !ofire && !flush_i;
      if (ofire) void'(mq.pop_front());
      if (flush_i) begin
        mq.delete();
      end else if (ifire) begin
        e.c = in_ctrl_i;
        e.d = in_data_i;
        mq.push_back(e);
      end
      if (mq.size() > 0) m_last = mq[0].d;
      m_ready = (mq.size() < 2);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk_i) begin
    logic              ev;
    logic [CTRL_W-1:0] ec;
    ev = (mq.size() > 0);
    ec = ev ? mq[0].c : BUB;
    chk("out_valid", DATA_W'(out_valid_o), DATA_W'(ev));
    chk("out_ctrl", DATA_W'(out_ctrl_o), DATA_W'(ec));
    chk("out_data", out_data_o, ev ? mq[0].d : m_last);
    chk("in_ready", DATA_W'(in_ready_o), DATA_W'(m_ready));
    chk("occupancy", DATA_W'(occupancy_o), DATA_W'(mq.size()));
    if (m_full_hold) chk("ready_rose_while_full", DATA_W'(in_ready_o), '0);
  end

  // Drive one cycle from a negedge; returns at the next negedge
  task automatic cyc(input logic v, input logic [CTRL_W-1:0] c,
                     input logic [DATA_W-1:0] d, input logic r, input logic f);
    in_valid_i  = v;
    in_ctrl_i   = c;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b0;
    #12;
    @(negedge clk_i);
    rst_i = 1'b1;

    // Idle after reset
    cyc(0, '0, '0, 0, 0);
    chk("rst_valid", DATA_W'(out_valid_o), '0);
    chk("rst_ctrl", DATA_W'(out_ctrl_o), DATA_W'(8'h0C));
    chk("rst_ready", DATA_W'(in_ready_o), DATA_W'(1'b1));
    chk("rst_occ", DATA_W'(occupancy_o), '0);
    chk("rst_data", out_data_o, '0);

    // Full-rate stream 1..8
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 8'h41, DATA_W'(i), 1, 0);
      chk("stream_data", out_data_o, DATA_W'(i));
      chk("stream_valid", DATA_W'(out_valid_o), DATA_W'(1'b1));
      chk("stream_occ", DATA_W'(occupancy_o), DATA_W'(1));
    end
    cyc(0, '0, '0, 1, 0);
    chk("drain_valid", DATA_W'(out_valid_o), '0);
    chk("drain_ctrl", DATA_W'(out_ctrl_o), DATA_W'(8'h0C));
    chk("drain_data_kept", out_data_o, DATA_W'(8));

    // Stall into the skid register
    cyc(1, 8'h21, DATA_W'(5), 0, 0);
    cyc(1, 8'h22, DATA_W'(6), 0, 0);
    chk("stall_occ", DATA_W'(occupancy_o), DATA_W'(2));
    chk("stall_ready", DATA_W'(in_ready_o), '0);
    chk("stall_data", out_data_o, DATA_W'(5));
    cyc(1, 8'h23, DATA_W'(99), 0, 0);
    chk("stall_hold_data", out_data_o, DATA_W'(5));
    chk("stall_hold_ctrl", DATA_W'(out_ctrl_o), DATA_W'(8'h21));
    cyc(0, '0, '0, 1, 0);
    chk("release_data6", out_data_o, DATA_W'(6));
    chk("release_ready", DATA_W'(in_ready_o), DATA_W'(1'b1));
    cyc(0, '0, '0, 1, 0);
    chk("release_empty", DATA_W'(occupancy_o), '0);

    // Flush while full, with an entry offered in the same cycle
    cyc(1, 8'h31, DATA_W'(7), 0, 0);
    cyc(1, 8'h32, DATA_W'(8), 0, 0);
    chk("pre_flush_occ", DATA_W'(occupancy_o), DATA_W'(2));
    cyc(1, 8'h33, DATA_W'(9), 0, 1);
    chk("flush_valid", DATA_W'(out_valid_o), '0);
    chk("flush_ctrl", DATA_W'(out_ctrl_o), DATA_W'(8'h0C));
    chk("flush_occ", DATA_W'(occupancy_o), '0);
    chk("flush_ready", DATA_W'(in_ready_o), DATA_W'(1'b1));
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, '0, 1, 0);
      chk("flush_no9", DATA_W'(out_valid_o), '0);
    end

    // Asynchronous reset while full
    cyc(1, 8'h11, DATA_W'(17), 0, 0);
    cyc(1, 8'h12, DATA_W'(18), 0, 0);
    chk("pre_arst_occ", DATA_W'(occupancy_o), DATA_W'(2));
    #2 rst_i = 1'b0;
    #1;
    chk("arst_valid", DATA_W'(out_valid_o), '0);
    chk("arst_ctrl", DATA_W'(out_ctrl_o), DATA_W'(8'h0C));
    chk("arst_occ", DATA_W'(occupancy_o), '0);
    chk("arst_ready", DATA_W'(in_ready_o), DATA_W'(1'b1));
    chk("arst_data", out_data_o, '0);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    cyc(1, 8'h5A, DATA_W'(8'hA), 1, 0);
    chk("post_arst_data", out_data_o, DATA_W'(8'hA));
    chk("post_arst_ctrl", DATA_W'(out_ctrl_o), DATA_W'(8'h5A));
    cyc(0, '0, '0, 1, 0);

    // Random handshake traffic with occasional flushes
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom),
          {$urandom, $urandom, $urandom, $urandom},
          1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
    end
    cyc(0, '0, '0, 1, 0);
    cyc(0, '0, '0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
